// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode/writeback/kill bundle for the register hazard scoreboard.
//   master : decode side. Drives issue, writeback and kill requests, and reads
//            stall, issue_ack, busy_vec, sb_err and stall_cycles.
//   slave  : scoreboard side, with every direction reversed.
`timescale 1ns/1ps
interface reg_scoreboard_if #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned AW    = 4
) ();
  logic             issue_valid;
  logic [AW-1:0]    src1_addr;
  logic [AW-1:0]    src2_addr;
  logic             src1_used;
  logic             src2_used;
  logic [AW-1:0]    dst_addr;
  logic             dst_write;
  logic             wb_valid;
  logic [AW-1:0]    wb_addr;
  logic             kill_valid;
  logic [AW-1:0]    kill_addr;
  logic             stall;
  logic             issue_ack;
  logic [NREGS-1:0] busy_vec;
  logic             sb_err;
  logic [15:0]      stall_cycles;

  modport master (
    output issue_valid, src1_addr, src2_addr, src1_used, src2_used, dst_addr, dst_write,
    output wb_valid, wb_addr, kill_valid, kill_addr,
    input  stall, issue_ack, busy_vec, sb_err, stall_cycles
  );

  modport slave (
    input  issue_valid, src1_addr, src2_addr, src1_used, src2_used, dst_addr, dst_write,
    input  wb_valid, wb_addr, kill_valid, kill_addr,
    output stall, issue_ack, busy_vec, sb_err, stall_cycles
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters that gate issue out of decode.
//   clk          : clock; all state changes on the rising edge
//   rst          : synchronous, active-high reset
//   sb (slave)   : issue request (sources, destination), writeback and kill releases.
//                  It returns stall and issue_ack (both combinational), busy_vec,
//                  the sticky underflow flag sb_err and the saturating stall_cycles.
// Optional feature: define SCOREBOARD_WB_BYPASS_EN when the register file forwards
// same-cycle writes. A source whose last pending write retires this cycle is then
// not a hazard. Kill releases never bypass.
`timescale 1ns/1ps
module reg_scoreboard #(
  parameter int unsigned NREGS   = 16,
  parameter int unsigned AW      = 4,
  parameter int unsigned MAXPEND = 3
) (
  input logic             clk,
  input logic             rst,
  reg_scoreboard_if.slave sb
);
  localparam int unsigned CW = $clog2(MAXPEND + 1);
  typedef logic [CW-1:0] cnt_t;

  cnt_t        cnt_q [NREGS];
  cnt_t        cnt_d [NREGS];
  logic        sb_err_q;
  logic        err_set;
  logic [15:0] stall_cycles_q;

  cnt_t src1_cnt, src2_cnt, dst_cnt;
  logic src1_haz, src2_haz, dst_haz;
  logic stall, issue_ack;

  // Entry 0 is held at zero, so R0 always reads as not busy.
  assign src1_cnt = cnt_q[sb.src1_addr];
  assign src2_cnt = cnt_q[sb.src2_addr];
  assign dst_cnt  = cnt_q[sb.dst_addr];

  always_comb begin
    src1_haz = sb.src1_used && (sb.src1_addr != '0) && (src1_cnt != '0);
    src2_haz = sb.src2_used && (sb.src2_addr != '0) && (src2_cnt != '0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    // The last outstanding write lands this cycle and is forwarded to the read.
    if (src1_cnt == cnt_t'(1) && sb.wb_valid && (sb.wb_addr == sb.src1_addr)) src1_haz = 1'b0;
    if (src2_cnt == cnt_t'(1) && sb.wb_valid && (sb.wb_addr == sb.src2_addr)) src2_haz = 1'b0;
`endif
    // Blocking at MAXPEND is what keeps the counters from overflowing.
    dst_haz   = sb.dst_write && (sb.dst_addr != '0) && (dst_cnt == cnt_t'(MAXPEND));
    stall     = sb.issue_valid && (src1_haz || src2_haz || dst_haz);
    issue_ack = sb.issue_valid && !stall;
  end

  assign sb.stall        = stall;
  assign sb.issue_ack    = issue_ack;
  assign sb.sb_err       = sb_err_q;
  assign sb.stall_cycles = stall_cycles_q;

  always_comb begin
    sb.busy_vec = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      sb.busy_vec[i] = (cnt_q[i] != '0);
    end
  end

  // Increment and both releases are folded into one signed-free update per register.
  // Releases beyond count+inc clamp to zero and flag an error.
  always_comb begin
    err_set  = 1'b0;
    cnt_d[0] = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      logic        inc;
      logic [1:0]  dec;
      logic [CW:0] sum;
      inc = issue_ack && sb.dst_write && (sb.dst_addr == AW'(i));
      dec = 2'(sb.wb_valid && (sb.wb_addr == AW'(i))) +
            2'(sb.kill_valid && (sb.kill_addr == AW'(i)));
      sum = {1'b0, cnt_q[i]} + (CW+1)'(inc);
      if ((CW+1)'(dec) > sum) begin
        cnt_d[i] = '0;
        err_set  = 1'b1;
      end else begin
        cnt_d[i] = CW'(sum - (CW+1)'(dec));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        cnt_q[i] <= '0;
      end
      sb_err_q       <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      if (err_set) sb_err_q <= 1'b1;
      if (stall && (stall_cycles_q != 16'hFFFF)) stall_cycles_q <= stall_cycles_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
`timescale 1ns/1ps
module tb_reg_scoreboard;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_scoreboard_if #(.NREGS(16), .AW(4)) sbif ();

  reg_scoreboard #(.NREGS(16), .AW(4), .MAXPEND(3)) dut (
    .clk(clk),
    .rst(rst),
    .sb (sbif)
  );

  typedef struct {
    string       name;
    logic        stall;
    logic        ack;
    logic [15:0] busy;
    logic        err;
    logic [15:0] sc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] sc_model;

  task automatic cmp(input string name, input string field, input logic [15:0] act,
                     input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s.%s: got %h, expected %h", name, field, act, want);
    end
  endtask

  // Monitor: each cycle with an expectation queued, compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      cmp(mon_e.name, "stall", 16'(sbif.stall), 16'(mon_e.stall));
      cmp(mon_e.name, "issue_ack", 16'(sbif.issue_ack), 16'(mon_e.ack));
      cmp(mon_e.name, "busy_vec", sbif.busy_vec, mon_e.busy);
      cmp(mon_e.name, "sb_err", 16'(sbif.sb_err), 16'(mon_e.err));
      cmp(mon_e.name, "stall_cycles", sbif.stall_cycles, mon_e.sc);
    end
  end

  task automatic drive(input logic iv, input logic [3:0] s1, input logic s1u,
                       input logic [3:0] s2, input logic s2u, input logic [3:0] d,
                       input logic dw, input logic wbv, input logic [3:0] wba,
                       input logic kv, input logic [3:0] ka);
    sbif.issue_valid = iv;
    sbif.src1_addr   = s1;
    sbif.src1_used   = s1u;
    sbif.src2_addr   = s2;
    sbif.src2_used   = s2u;
    sbif.dst_addr    = d;
    sbif.dst_write   = dw;
    sbif.wb_valid    = wbv;
    sbif.wb_addr     = wba;
    sbif.kill_valid  = kv;
    sbif.kill_addr   = ka;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Push the expectation for the current cycle; stall_cycles seen is the start-of-cycle value.
  task automatic expect_out(input string name, input logic st, input logic ack,
                            input logic [15:0] busy, input logic err);
    exp_q.push_back('{name, st, ack, busy, err, sc_model});
    if (st && sc_model != 16'hFFFF) sc_model = sc_model + 16'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    sc_model = '0;
    idle();
    tick();
    expect_out("reset", 0, 0, 16'h0000, 0);
    tick();
    rst = 1'b0;

    // RAW on R3 released by writeback
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0); expect_out("t1_issue_r3", 0, 1, 16'h0000, 0); tick();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("t1_raw", 1, 0, 16'h0008, 0); tick();
    drive(1, 3, 1, 0, 0, 0, 0, 1, 3, 0, 0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    expect_out("t1_wb_cycle", 0, 1, 16'h0008, 0); tick();
    idle(); expect_out("t1_after_wb", 0, 0, 16'h0000, 0); tick();
`else
    expect_out("t1_wb_cycle", 1, 0, 16'h0008, 0); tick();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("t1_after_wb", 0, 1, 16'h0000, 0); tick();
`endif

    // R5 saturates at MAXPEND, dst hazard
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); expect_out("t2_w1", 0, 1, 16'h0000, 0); tick();
    expect_out("t2_w2", 0, 1, 16'h0020, 0); tick();
    expect_out("t2_w3", 0, 1, 16'h0020, 0); tick();
    expect_out("t2_w4_stall", 1, 0, 16'h0020, 0); tick();
    drive(1, 0, 0, 0, 0, 5, 1, 1, 5, 0, 0); expect_out("t2_w4_wb", 1, 0, 16'h0020, 0); tick();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0); expect_out("t2_w4_issue", 0, 1, 16'h0020, 0); tick();
    expect_out("t2_full_again", 1, 0, 16'h0020, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0); expect_out("t2_drain1", 0, 0, 16'h0020, 0); tick();
    expect_out("t2_drain2", 0, 0, 16'h0020, 0); tick();
    expect_out("t2_drain3", 0, 0, 16'h0020, 0); tick();
    idle(); expect_out("t2_empty", 0, 0, 16'h0000, 0); tick();

    // R0 is never tracked
    drive(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0); expect_out("t3_r0_a", 0, 1, 16'h0000, 0); tick();
    drive(1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0); expect_out("t3_r0_b", 0, 1, 16'h0000, 0); tick();
    idle(); expect_out("t3_r0_done", 0, 0, 16'h0000, 0); tick();

    // R7: issue plus wb plus kill in one cycle, then underflow
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0); expect_out("t4_issue", 0, 1, 16'h0000, 0); tick();
    drive(1, 0, 0, 0, 0, 7, 1, 1, 7, 1, 7); expect_out("t4_net", 0, 1, 16'h0080, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0); expect_out("t4_zero", 0, 0, 16'h0000, 0); tick();
    idle(); expect_out("t4_underflow", 0, 0, 16'h0000, 1); tick();

    // Source equal to dst uses pre-issue count; src_used gating; kill never bypasses
    drive(1, 2, 1, 0, 0, 2, 1, 0, 0, 0, 0); expect_out("t5_self", 0, 1, 16'h0000, 1); tick();
    drive(1, 2, 0, 9, 1, 0, 0, 0, 0, 0, 0); expect_out("t5_unused", 0, 1, 16'h0004, 1); tick();
    drive(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0); expect_out("t5_src2", 1, 0, 16'h0004, 1); tick();
    drive(1, 0, 0, 2, 1, 0, 0, 0, 0, 1, 2); expect_out("t5_kill", 1, 0, 16'h0004, 1); tick();
    drive(1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0); expect_out("t5_released", 0, 1, 16'h0000, 1); tick();

    // stall_cycles saturation, then reset
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0); expect_out("t6_issue_r1", 0, 1, 16'h0000, 1); tick();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("t6_hold", 1, 0, 16'h0002, 1); tick();
    for (int i = 0; i < 69999; i++) tick();
    sc_model = 16'hFFFF;
    expect_out("t6_saturated", 1, 0, 16'h0002, 1); tick();
    rst = 1'b1;
    idle(); expect_out("t6_rst_cycle", 0, 0, 16'h0002, 1); tick();
    rst = 1'b0;
    sc_model = '0;
    expect_out("t6_post_rst", 0, 0, 16'h0000, 0); tick();
    drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); expect_out("t6_r1_cleared", 0, 1, 16'h0000, 0); tick();
    idle();
    tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
